// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state type for the 8-way round-robin arbiter
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/mux8.sv
// mux8: 8-to-1 payload multiplexer
module mux8 #(
  parameter int width = 32
) (
  input  logic [7:0][width-1:0] d,
  input  logic [2:0]            sel,
  output logic [width-1:0]      y
);
  assign y = d[sel];
endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: rotate-priority picker, first set request at or after ptr (wrapping)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [SEL_W-1:0]     off;
  always_comb begin
    dbl = {req, req} >> ptr;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = dbl[i] ? SEL_W'(i) : off;
    any = |req;
    idx = ptr + off;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: packet-locked round-robin arbiter sharing one valid/ready port among 8 requesters
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [SEL_W-1:0]                sel,
  output logic                            grant_act
);
  localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
  arb_state_t       state;
  logic [SEL_W-1:0] ptr, pick_idx;
  logic [CW-1:0]    beat_cnt;
  logic             pick_any, busy, beat, rel;
  rr_pick8 u_pick (.req(req_valid), .ptr(ptr), .any(pick_any), .idx(pick_idx));
  mux8 #(.width(WIDTH)) u_mux (.d(req_data), .sel(sel), .y(out_data));
  assign busy      = state == BUSY;
  assign grant_act = busy;
  assign out_valid = busy & req_valid[sel];
  assign out_last  = busy & req_last[sel];
  assign req_ready = {{(NUM_REQ-1){1'b0}}, busy & out_ready} << sel;
  assign beat      = out_valid & out_ready;
  assign rel       = beat & (req_last[sel] | (MAX_BURST != 0 && beat_cnt == LAST_CNT));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else if (!busy) begin
      if (pick_any) begin
        state    <= BUSY;
        sel      <= pick_idx;
        beat_cnt <= '0;
      end
    end else if (beat) begin
      beat_cnt <= (MAX_BURST != 0) ? beat_cnt + CW'(1) : beat_cnt;
      if (rel) begin
        state <= IDLE;
        ptr   <= sel + SEL_W'(1);
      end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed table-driven check of rr_arbiter8 (WIDTH=32, MAX_BURST=4)
module tb_rr_arbiter8;
  logic             clk = 0, rst_n = 0;
  logic [7:0]       req_valid = '0, req_last = '0, req_ready;
  logic [7:0][31:0] req_data;
  logic             out_valid, out_last, out_ready = 0, grant_act;
  logic [31:0]      out_data;
  logic [2:0]       sel;
  int               n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [7:0] valid, last;
    logic       ordy;
    logic [2:0] sel;
    logic       ov;
    logic [7:0] rr;
    logic       ga;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  rr_arbiter8 #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant_act(grant_act));
  function automatic logic [31:0] dat(input logic [2:0] i);
    return 32'h10203040 + 32'h01010101 * {29'd0, i};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] v, input logic [7:0] l, input logic o,
                     input logic [2:0] s, input logic ov, input logic [7:0] rr, input logic ga);
    vec_t e;
    e.valid = v; e.last = l; e.ordy = o; e.sel = s; e.ov = ov; e.rr = rr; e.ga = ga;
    tbl.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) req_data[i] = dat(3'(i));
    // single request from 3
    add(8'h08, 8'h08, 1, 0, 0, 8'h00, 0);
    add(8'h08, 8'h08, 1, 3, 1, 8'h08, 1);
    add(8'h00, 8'h00, 1, 3, 0, 8'h00, 0);
    // all valid, single-beat packets: rotation from ptr=4
    add(8'hff, 8'hff, 1, 3, 0, 8'h00, 0);
    add(8'hff, 8'hff, 1, 4, 1, 8'h10, 1);
    add(8'hff, 8'hff, 1, 4, 0, 8'h00, 0);
    add(8'hff, 8'hff, 1, 5, 1, 8'h20, 1);
    add(8'hff, 8'hff, 1, 5, 0, 8'h00, 0);
    add(8'hff, 8'hff, 1, 6, 1, 8'h40, 1);
    add(8'hff, 8'hff, 1, 6, 0, 8'h00, 0);
    add(8'hff, 8'hff, 1, 7, 1, 8'h80, 1);
    add(8'hff, 8'hff, 1, 7, 0, 8'h00, 0);
    add(8'hff, 8'hff, 1, 0, 1, 8'h01, 1);
    add(8'hff, 8'hff, 1, 0, 0, 8'h00, 0);
    add(8'hff, 8'hff, 1, 1, 1, 8'h02, 1);
    // req 2 streams without last: forced release after 4 beats, 5 served next
    add(8'h24, 8'h20, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(8'h24, 8'h20, 1, 2, 1, 8'h04, 1);
    add(8'h24, 8'h20, 1, 2, 0, 8'h00, 0);
    add(8'h24, 8'h20, 1, 5, 1, 8'h20, 1);
    add(8'h24, 8'h20, 1, 5, 0, 8'h00, 0);
    add(8'h24, 8'h20, 1, 2, 1, 8'h04, 1);
    // backpressure after one beat: counter must hold, so 3 more beats to release
    for (int i = 0; i < 5; i++) add(8'h04, 8'h00, 0, 2, 1, 8'h00, 1);
    for (int i = 0; i < 3; i++) add(8'h04, 8'h00, 1, 2, 1, 8'h04, 1);
    add(8'h04, 8'h00, 1, 2, 0, 8'h00, 0);
    // valid dropped mid-grant: lock held, no beat
    add(8'h00, 8'h00, 1, 2, 0, 8'h04, 1);
    add(8'h00, 8'h00, 1, 2, 0, 8'h04, 1);
    add(8'h04, 8'h04, 1, 2, 1, 8'h04, 1);
    // serve 6 so ptr=7, then wrap 7 -> 0
    add(8'h40, 8'h40, 1, 2, 0, 8'h00, 0);
    add(8'h40, 8'h40, 1, 6, 1, 8'h40, 1);
    add(8'h81, 8'h81, 1, 6, 0, 8'h00, 0);
    add(8'h81, 8'h81, 1, 7, 1, 8'h80, 1);
    add(8'h81, 8'h81, 1, 7, 0, 8'h00, 0);
    add(8'h81, 8'h81, 1, 0, 1, 8'h01, 1);
    add(8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    out_ready = 1;
    req_valid = 8'hff;
    #2;
    chk("rst_ready", req_ready, 8'h00);
    chk("rst_valid", out_valid, 0);
    chk("rst_grant", grant_act, 0);
    chk("rst_sel", sel, 0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1;
    foreach (tbl[k]) begin
      req_valid = tbl[k].valid;
      req_last = tbl[k].last;
      out_ready = tbl[k].ordy;
      #2;
      chk($sformatf("v%0d_sel", k), sel, tbl[k].sel);
      chk($sformatf("v%0d_ovalid", k), out_valid, tbl[k].ov);
      chk($sformatf("v%0d_rready", k), req_ready, tbl[k].rr);
      chk($sformatf("v%0d_grant", k), grant_act, tbl[k].ga);
      chk($sformatf("v%0d_data", k), out_data, dat(tbl[k].sel));
      chk($sformatf("v%0d_olast", k), out_last, tbl[k].ga & tbl[k].last[tbl[k].sel]);
      tick();
    end
    // reset during the second beat of a packet from 2
    req_valid = 8'h04;
    req_last = 8'h00;
    out_ready = 1;
    tick();
    tick();
    chk("mid_sel", sel, 2);
    chk("mid_ready", req_ready, 8'h04);
    rst_n = 0;
    #1;
    chk("arst_ready", req_ready, 8'h00);
    chk("arst_valid", out_valid, 0);
    chk("arst_grant", grant_act, 0);
    chk("arst_sel", sel, 0);
    tick();
    rst_n = 1;
    req_valid = 8'h0a;
    req_last = 8'h0a;
    #2;
    chk("post_idle", grant_act, 0);
    tick();
    chk("post_sel", sel, 1);
    chk("post_ready", req_ready, 8'h02);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
